// File: rtl/ps2_scan_sequencer.sv
// PS/2 keyboard front end: synchronises kbclk/in, deframes 11-bit frames and folds E0/F0 prefixes
// into make/break events behind a one-entry valid/ready buffer. Define PS2_TIMEOUT_EN for the frame watchdog.
module ps2_scan_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbclk,
  input  logic       in,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PAR, F_STOP} frame_state_t;
  typedef enum logic [1:0] {P_IDLE, P_E0, P_F0, P_E0F0} prefix_state_t;

  frame_state_t           frame_state;
  prefix_state_t          prefix_state;
  logic [SYNC_STAGES-1:0] kb_sync;
  logic [SYNC_STAGES-1:0] in_sync;
  logic                   kb_prev;
  logic                   kb_s;
  logic                   in_s;
  logic                   fall;
  logic [7:0]             shift_reg;
  logic [7:0]             byte_data;
  logic [2:0]             bit_cnt;
  logic                   par_bit;
  logic                   par_ok;
  logic                   byte_stb;
  logic                   is_prefix;
  logic                   emit;
  logic                   load;

  // Both lines idle high, so the chains reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_sync <= '1;
      in_sync <= '1;
      kb_prev <= 1'b1;
    end else begin
      kb_sync <= {kb_sync[SYNC_STAGES-2:0], kbclk};
      in_sync <= {in_sync[SYNC_STAGES-2:0], in};
      kb_prev <= kb_sync[SYNC_STAGES-1];
    end
  end

  assign kb_s   = kb_sync[SYNC_STAGES-1];
  assign in_s   = in_sync[SYNC_STAGES-1];
  assign fall   = kb_prev & ~kb_s;
  assign par_ok = ^{shift_reg, par_bit};

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          timeout_hit;

  assign timeout_hit = (frame_state != F_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (fall || (frame_state == F_IDLE) || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_state <= F_IDLE;
      shift_reg   <= '0;
      byte_data   <= '0;
      bit_cnt     <= '0;
      par_bit     <= 1'b0;
      byte_stb    <= 1'b0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      byte_stb   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      if (timeout_hit) begin
        frame_state <= F_IDLE;
        shift_reg   <= '0;
        bit_cnt     <= '0;
        err_frame   <= 1'b1;
      end else
`endif
      if (fall) begin
        case (frame_state)
          F_IDLE: begin
            if (!in_s) begin
              frame_state <= F_DATA;
              bit_cnt     <= '0;
            end
          end
          F_DATA: begin
            shift_reg <= {in_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              frame_state <= F_PAR;
            end
          end
          F_PAR: begin
            par_bit     <= in_s;
            frame_state <= F_STOP;
          end
          F_STOP: begin
            frame_state <= F_IDLE;
            // A parity error masks a simultaneous stop error.
            if (!par_ok) begin
              err_parity <= 1'b1;
            end else if (!in_s) begin
              err_frame <= 1'b1;
            end else begin
              byte_stb  <= 1'b1;
              byte_data <= shift_reg;
            end
          end
          default: frame_state <= F_IDLE;
        endcase
      end
    end
  end

  assign is_prefix = (byte_data == 8'hE0) || (byte_data == 8'hF0);
  assign emit      = byte_stb && !is_prefix;
  assign load      = emit && (!evt_valid || evt_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefix_state <= P_IDLE;
    end else if (err_parity || err_frame) begin
      prefix_state <= P_IDLE;
    end else if (byte_stb) begin
      case (prefix_state)
        P_IDLE: begin
          if (byte_data == 8'hE0) begin
            prefix_state <= P_E0;
          end else if (byte_data == 8'hF0) begin
            prefix_state <= P_F0;
          end
        end
        P_E0: begin
          if (byte_data == 8'hF0) begin
            prefix_state <= P_E0F0;
          end else if (byte_data != 8'hE0) begin
            prefix_state <= P_IDLE;
          end
        end
        P_F0, P_E0F0: begin
          if (!is_prefix) begin
            prefix_state <= P_IDLE;
          end
        end
        default: prefix_state <= P_IDLE;
      endcase
    end
  end

  // Event buffer: a drain and a reload in the same cycle keep evt_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_ext   <= 1'b0;
      evt_brk   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= byte_data;
        evt_ext   <= (prefix_state == P_E0) || (prefix_state == P_E0F0);
        evt_brk   <= (prefix_state == P_F0) || (prefix_state == P_E0F0);
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (emit && !load) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign busy = (frame_state != F_IDLE) || (prefix_state != P_IDLE);

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: frames are driven on the clk negedge so edge-to-event latency is exact.
module tb_ps2_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kbclk;
  logic       in;
  logic       evt_ready;
  logic       ovf_clr;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;
  logic       busy;

  int         errors = 0;
  int         checks = 0;
  int         evt_count = 0;
  int         par_count = 0;
  int         frm_count = 0;
  logic [7:0] last_code = '0;
  logic       last_ext = 1'b0;
  logic       last_brk = 1'b0;

  ps2_scan_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .kbclk(kbclk), .in(in),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk),
    .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record accepted events and error-pulse cycles as the consumer would see them.
  always @(posedge clk) begin
    if (evt_valid && evt_ready) begin
      evt_count = evt_count + 1;
      last_code = evt_code;
      last_ext  = evt_ext;
      last_brk  = evt_brk;
    end
    if (err_parity) par_count = par_count + 1;
    if (err_frame)  frm_count = frm_count + 1;
  end

  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in    = bits[i];
      kbclk = 1'b1;
      repeat (5) @(negedge clk);
      kbclk = 1'b0;
      if (i < n - 1) repeat (5) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^d) ^ bad_par;
    send_raw({~bad_stop, p, d, 1'b0}, 11);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    kbclk = 1'b1;
    in    = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; kbclk = 1'b1; in = 1'b1; evt_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (evt_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_valid got %b want 0", evt_valid); end
    checks++; if (evt_code !== 8'h00)  begin errors++; $display("[TB] FAIL reset_code got %h want 00", evt_code); end
    checks++; if ({evt_ext, evt_brk} !== 2'b00) begin errors++; $display("[TB] FAIL reset_extbrk got %b want 00", {evt_ext, evt_brk}); end
    checks++; if ({err_parity, err_frame} !== 2'b00) begin errors++; $display("[TB] FAIL reset_err got %b want 00", {err_parity, err_frame}); end
    checks++; if ({overflow, busy} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ovf_busy got %b want 00", {overflow, busy}); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    // Reset mid-frame must abandon the partial frame immediately.
    send_raw(11'b000_0000_1010, 4);
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midframe_busy got %b want 1", busy); end
    kbclk = 1'b1; in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_make;
    int base;
    base = evt_count;
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL make_early got %b want 0", evt_valid); end
    @(posedge clk); #1;
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("[TB] FAIL make_latency got %b want 1", evt_valid); end
    checks++; if ({evt_code, evt_ext, evt_brk} !== {8'h1C, 2'b00}) begin
      errors++; $display("[TB] FAIL make_event got %h/%b%b want 1C/00", evt_code, evt_ext, evt_brk);
    end
    @(posedge clk); #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL make_width got %b want 0", evt_valid); end
    idle(5);
    checks++; if (evt_count - base !== 1) begin errors++; $display("[TB] FAIL make_count got %0d want 1", evt_count - base); end
  endtask

  task automatic test_break;
    int base;
    base = evt_count;
    send_frame(8'hF0, 1'b0, 1'b0);
    idle(10);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy got %b want 1", busy); end
    checks++; if (evt_count - base !== 0) begin errors++; $display("[TB] FAIL break_prefix_evt got %0d want 0", evt_count - base); end
    send_frame(8'h1C, 1'b0, 1'b0);
    idle(10);
    checks++; if (evt_count - base !== 1) begin errors++; $display("[TB] FAIL break_count got %0d want 1", evt_count - base); end
    checks++; if ({last_code, last_ext, last_brk} !== {8'h1C, 2'b01}) begin
      errors++; $display("[TB] FAIL break_event got %h/%b%b want 1C/01", last_code, last_ext, last_brk);
    end
  endtask

  task automatic test_ext_break;
    int base;
    base = evt_count;
    send_frame(8'hE0, 1'b0, 1'b0); idle(5);
    send_frame(8'hF0, 1'b0, 1'b0); idle(5);
    send_frame(8'h75, 1'b0, 1'b0); idle(10);
    checks++; if (evt_count - base !== 1) begin errors++; $display("[TB] FAIL extbrk_count got %0d want 1", evt_count - base); end
    checks++; if ({last_code, last_ext, last_brk} !== {8'h75, 2'b11}) begin
      errors++; $display("[TB] FAIL extbrk_event got %h/%b%b want 75/11", last_code, last_ext, last_brk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL extbrk_busy got %b want 0", busy); end
    send_frame(8'hE1, 1'b0, 1'b0); idle(10);
    checks++; if ({last_code, last_ext, last_brk} !== {8'hE1, 2'b00}) begin
      errors++; $display("[TB] FAIL e1_event got %h/%b%b want E1/00", last_code, last_ext, last_brk);
    end
  endtask

  task automatic test_errors;
    int base, bp, bf;
    base = evt_count; bp = par_count; bf = frm_count;
    send_frame(8'h1C, 1'b1, 1'b0); idle(10);
    checks++; if (par_count - bp !== 1) begin errors++; $display("[TB] FAIL parity_pulse got %0d want 1", par_count - bp); end
    checks++; if (evt_count - base !== 0) begin errors++; $display("[TB] FAIL parity_evt got %0d want 0", evt_count - base); end
    send_frame(8'hE0, 1'b0, 1'b0); idle(5);
    send_frame(8'h12, 1'b1, 1'b0); idle(5);
    send_frame(8'h75, 1'b0, 1'b0); idle(10);
    checks++; if ({last_code, last_ext, evt_count - base} !== {8'h75, 1'b0, 32'sd1}) begin
      errors++; $display("[TB] FAIL parity_prefix_clear got %h ext=%b n=%0d want 75 ext=0 n=1", last_code, last_ext, evt_count - base);
    end
    bp = par_count; bf = frm_count; base = evt_count;
    send_frame(8'h1C, 1'b0, 1'b1); idle(10);
    checks++; if ({par_count - bp, frm_count - bf} !== {32'sd0, 32'sd1}) begin
      errors++; $display("[TB] FAIL stop_bad got par=%0d frm=%0d want 0/1", par_count - bp, frm_count - bf);
    end
    bp = par_count; bf = frm_count;
    send_frame(8'h1C, 1'b1, 1'b1); idle(10);
    checks++; if ({par_count - bp, frm_count - bf} !== {32'sd1, 32'sd0}) begin
      errors++; $display("[TB] FAIL both_bad got par=%0d frm=%0d want 1/0", par_count - bp, frm_count - bf);
    end
    checks++; if (evt_count - base !== 0) begin errors++; $display("[TB] FAIL bad_frames_evt got %0d want 0", evt_count - base); end
  endtask

  task automatic test_overflow;
    int base;
    evt_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0); idle(5);
    send_frame(8'h32, 1'b0, 1'b0); idle(10);
    checks++; if ({evt_valid, evt_code, overflow} !== {1'b1, 8'h1C, 1'b1}) begin
      errors++; $display("[TB] FAIL ovf_hold got v=%b code=%h ovf=%b want 1/1C/1", evt_valid, evt_code, overflow);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b want 0", overflow); end
    // Hold ovf_clr through another dropped event: the set cycle must win.
    ovf_clr = 1'b1;
    send_frame(8'h32, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins got %b want 1", overflow); end
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear_after got %b want 0", overflow); end
    idle(5);
    ovf_clr = 1'b0;
    base = evt_count;
    evt_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid got %b want 0", evt_valid); end
    checks++; if ({last_code, evt_count - base} !== {8'h1C, 32'sd1}) begin
      errors++; $display("[TB] FAIL drain_event got %h n=%0d want 1C n=1", last_code, evt_count - base);
    end
    idle(5);
  endtask

  task automatic test_back_to_back;
    int base;
    base = evt_count;
    send_frame(8'h1C, 1'b0, 1'b0); idle(2);
    send_frame(8'h32, 1'b0, 1'b0); idle(10);
    checks++; if ({evt_count - base, last_code} !== {32'sd2, 8'h32}) begin
      errors++; $display("[TB] FAIL b2b got n=%0d code=%h want 2/32", evt_count - base, last_code);
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf got %b want 0", overflow); end
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout;
    int bf, waited;
    bit seen;
    bf = frm_count; waited = 0; seen = 1'b0;
    send_raw(11'b000_0000_1010, 4);
    while (!seen && waited < 300) begin
      @(posedge clk); #1;
      waited++;
      if (waited == 8) kbclk = 1'b1;
      if (err_frame) seen = 1'b1;
    end
    checks++; if (!seen || waited < 101 || waited > 105) begin
      errors++; $display("[TB] FAIL timeout_latency got seen=%b cycles=%0d want 103", seen, waited);
    end
    @(posedge clk); #1;
    checks++; if ({busy, frm_count - bf} !== {1'b0, 32'sd1}) begin
      errors++; $display("[TB] FAIL timeout_state got busy=%b frm=%0d want 0/1", busy, frm_count - bf);
    end
    idle(5);
    send_frame(8'h1C, 1'b0, 1'b0); idle(10);
    checks++; if ({last_code, last_ext, last_brk} !== {8'h1C, 2'b00}) begin
      errors++; $display("[TB] FAIL timeout_recover got %h/%b%b want 1C/00", last_code, last_ext, last_brk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_make();
    test_break();
    test_ext_break();
    test_errors();
    test_overflow();
    test_back_to_back();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
